// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: LocalLink transmit framer for the Aurora user interface.
// A first-word-fall-through FIFO buffers the valid/ready input stream; a two-state
// machine cuts it into frames of FRAME_LEN words, or shorter frames when the
// stream stalls longer than FLUSH_TIMEOUT idle cycles.
module aurora_tx_framer #(
  parameter int DATA_W  = 32,
  parameter int REM_W   = 2,
  parameter int FIFO_AW = 6,
  parameter int LEN_W   = 8,
  parameter int TO_W    = 8
) (
  input  logic                USER_CLK,
  input  logic                RESET,
  input  logic [DATA_W-1:0]   IN_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [LEN_W-1:0]    FRAME_LEN,
  input  logic [TO_W-1:0]     FLUSH_TIMEOUT,
  output logic [0:DATA_W-1]   TX_D,
  output logic [0:REM_W-1]    TX_REM,
  output logic                TX_SOF_N,
  output logic                TX_EOF_N,
  output logic                TX_SRC_RDY_N,
  input  logic                TX_DST_RDY_N,
  output logic [FIFO_AW:0]    FIFO_LEVEL,
  output logic [15:0]         FRAME_CNT
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  // common width for frame length, level and beat counter comparisons
  localparam int CW    = (LEN_W > LW) ? LEN_W : LW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      n_q, n_d, beat_q, beat_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic          push, pop, beat, sending, is_eof, to_fire;
  logic [CW-1:0] len_eff, level_ext;

  assign sending   = (state_q == S_SEND);
  assign beat      = sending && !TX_DST_RDY_N;
  assign pop       = beat;
  assign push      = IN_VALID && IN_READY;
  assign is_eof    = (beat_q == n_q - CW'(1));
  assign level_ext = CW'(level_q);
  assign to_fire   = (FLUSH_TIMEOUT != '0) && (to_q == FLUSH_TIMEOUT);

  // effective frame length: FRAME_LEN clamped to [1, DEPTH]
  always_comb begin
    len_eff = CW'(FRAME_LEN);
    if (FRAME_LEN == '0) len_eff = CW'(1);
    if (len_eff > CW'(DEPTH)) len_eff = CW'(DEPTH);
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level alone
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  // frame state machine; a full-length start wins over a timeout start
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    beat_d  = beat_q;
    fcnt_d  = fcnt_q;
    if (!sending) begin
      if (level_ext >= len_eff) begin
        state_d = S_SEND;
        n_d     = len_eff;
        beat_d  = '0;
      end else if (to_fire && level_q != '0) begin
        state_d = S_SEND;
        n_d     = level_ext;
        beat_d  = '0;
      end
    end else if (beat) begin
      if (is_eof) begin
        state_d = S_IDLE;
        beat_d  = '0;
        fcnt_d  = fcnt_q + 16'd1;
      end else begin
        beat_d  = beat_q + CW'(1);
      end
    end
  end

  // idle timeout: runs only while idle with data waiting, saturates at all-ones
  always_comb begin
    to_d = to_q;
    if (sending || level_q == '0 || FLUSH_TIMEOUT == '0) to_d = '0;
    else if (to_q != '1)                                  to_d = to_q + TO_W'(1);
  end

  // control state registers with synchronous reset
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      n_q      <= CW'(1);
      beat_q   <= '0;
      to_q     <= '0;
      fcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      n_q      <= n_d;
      beat_q   <= beat_d;
      to_q     <= to_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // FIFO storage; contents need no reset since the level gates visibility
  always_ff @(posedge USER_CLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  assign IN_READY     = (level_q < LW'(DEPTH));
  assign FIFO_LEVEL   = level_q;
  assign FRAME_CNT    = fcnt_q;
  assign TX_D         = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign TX_REM       = '1;
  assign TX_SRC_RDY_N = !sending;
  assign TX_SOF_N     = !(sending && beat_q == '0);
  assign TX_EOF_N     = !(sending && is_eof);

endmodule

// File: tb/tb_aurora_tx_framer.sv
// tb_aurora_tx_framer: directed scoreboard bench for aurora_tx_framer.
// Stimulus pushes the expected beat (data, SOF, EOF) into a queue as each word is
// offered; a monitor pops and compares on every accepted LocalLink beat.
module tb_aurora_tx_framer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  FRAME_LEN = 8'd4;
  logic [7:0]  FLUSH_TIMEOUT = 8'd0;
  logic [0:31] TX_D;
  logic [0:1]  TX_REM;
  logic        TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N;
  logic        TX_DST_RDY_N = 1'b0;
  logic [6:0]  FIFO_LEVEL;
  logic [15:0] FRAME_CNT;

  aurora_tx_framer dut (
    .USER_CLK(clk), .RESET(RESET),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FRAME_LEN(FRAME_LEN), .FLUSH_TIMEOUT(FLUSH_TIMEOUT),
    .TX_D(TX_D), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .FIFO_LEVEL(FIFO_LEVEL), .FRAME_CNT(FRAME_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int beats = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: scoreboard pops on beats, holds outputs stable under backpressure,
  // and requires an idle cycle after every EOF beat
  logic        stall_prev = 1'b0;
  logic        gap_chk = 1'b0;
  logic [34:0] prev_o;
  always @(negedge clk) begin
    if (!RESET) begin
      if (gap_chk) begin
        total++;
        if (TX_SRC_RDY_N !== 1'b1) begin
          bad++;
          $display("FAIL gap_after_eof: src_rdy_n=%b expected 1", TX_SRC_RDY_N);
        end
      end
      gap_chk = 1'b0;
      if (stall_prev) begin
        total++;
        if ({TX_D, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N} !== prev_o) begin
          bad++;
          $display("FAIL hold_stable: got %h expected %h",
                   {TX_D, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N}, prev_o);
        end
      end
      if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
        exp_t e;
        beats++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: data %h with no word expected", TX_D);
        end else begin
          e = q.pop_front();
          if ({TX_D, ~TX_SOF_N, ~TX_EOF_N} !== {e.d, e.sof, e.eof}) begin
            bad++;
            $display("FAIL beat: got d=%h sof=%b eof=%b expected d=%h sof=%b eof=%b",
                     TX_D, ~TX_SOF_N, ~TX_EOF_N, e.d, e.sof, e.eof);
          end
        end
        if (!TX_EOF_N) gap_chk = 1'b1;
      end
      stall_prev = !TX_SRC_RDY_N && TX_DST_RDY_N;
      prev_o     = {TX_D, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N};
    end else begin
      stall_prev = 1'b0;
      gap_chk    = 1'b0;
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    q.delete();
    beats = 0;
  endtask

  // offer one word and wait for it to be accepted; expected beat queued first
  task automatic push(input logic [31:0] d, input bit sof, input bit eof);
    exp_t e;
    int n = 0;
    IN_DATA  = d;
    IN_VALID = 1'b1;
    e.d = d; e.sof = sof; e.eof = eof;
    q.push_back(e);
    while (1) begin
      @(negedge clk);
      if (IN_READY) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("FAIL push_timeout: word %h not accepted", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_frames(input int t, input int budget);
    int n = 0;
    while (FRAME_CNT != 16'(t)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        total++; bad++;
        $display("FAIL frame_wait: frame_cnt=%0d expected %0d", FRAME_CNT, t);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset();
    chk("rst_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("rst_sof_n",     64'(TX_SOF_N),     64'd1);
    chk("rst_eof_n",     64'(TX_EOF_N),     64'd1);
    chk("rst_rem",       64'(TX_REM),       64'd3);
    chk("rst_in_ready",  64'(IN_READY),     64'd1);
    chk("rst_level",     64'(FIFO_LEVEL),   64'd0);
    chk("rst_frame_cnt", 64'(FRAME_CNT),    64'd0);
    chk("rst_tx_d",      64'(TX_D),         64'd0);

    // two 4-word frames from 8 back-to-back words
    FRAME_LEN = 8'd4; FLUSH_TIMEOUT = 8'd0; TX_DST_RDY_N = 1'b0;
    for (int i = 0; i < 8; i++) push(32'(i + 1), (i % 4) == 0, (i % 4) == 3);
    wait_frames(2, 100);
    repeat (2) @(negedge clk);
    chk("t1_frame_cnt", 64'(FRAME_CNT), 64'd2);
    chk("t1_beats",     64'(beats),     64'd8);
    chk("t1_q_empty",   64'(q.size()),  64'd0);

    // single-word frame, start latency of two cycles
    do_reset();
    FRAME_LEN = 8'd1;
    push(32'hA5A5_A5A5, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("t2_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd0);
    chk("t2_sof_n",     64'(TX_SOF_N),     64'd0);
    chk("t2_eof_n",     64'(TX_EOF_N),     64'd0);
    chk("t2_tx_d",      64'(TX_D),         64'hA5A5_A5A5);
    wait_frames(1, 20);
    chk("t2_q_empty",   64'(q.size()),     64'd0);

    // flush timeout sends a short 3-word frame
    do_reset();
    FRAME_LEN = 8'd8; FLUSH_TIMEOUT = 8'd10;
    push(32'hC0DE_0001, 1'b1, 1'b0);
    push(32'hC0DE_0002, 1'b0, 1'b0);
    push(32'hC0DE_0003, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("t3_no_early_flush", 64'(TX_SRC_RDY_N), 64'd1);
    wait_frames(1, 100);
    repeat (2) @(negedge clk);
    chk("t3_frame_cnt", 64'(FRAME_CNT), 64'd1);
    chk("t3_q_empty",   64'(q.size()),  64'd0);

    // pseudo-random destination backpressure during a 4-word frame
    do_reset();
    FRAME_LEN = 8'd4; FLUSH_TIMEOUT = 8'd0;
    TX_DST_RDY_N = 1'b1;
    fork
      begin
        logic [7:0] lfsr = 8'b1011_0101;
        repeat (30) begin
          @(posedge clk); #1;
          TX_DST_RDY_N = lfsr[0];
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        TX_DST_RDY_N = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) push(32'hBEEF_0000 + 32'(i), i == 0, i == 3);
        wait_frames(1, 200);
      end
    join
    repeat (2) @(negedge clk);
    chk("t4_beats",     64'(beats),    64'd4);
    chk("t4_q_empty",   64'(q.size()), 64'd0);

    // fill the FIFO under held backpressure, then drain everything in order
    do_reset();
    FRAME_LEN = 8'd4; TX_DST_RDY_N = 1'b1;
    fork
      begin
        for (int i = 0; i < 68; i++) push(32'h1000 + 32'(i), (i % 4) == 0, (i % 4) == 3);
      end
      begin
        int n = 0;
        while (FIFO_LEVEL != 7'd64 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("t5_in_ready_full", 64'(IN_READY),   64'd0);
        chk("t5_level_full",    64'(FIFO_LEVEL), 64'd64);
        @(posedge clk); #1;
        TX_DST_RDY_N = 1'b0;
      end
    join
    wait_frames(17, 2000);
    repeat (2) @(negedge clk);
    chk("t5_beats",   64'(beats),      64'd68);
    chk("t5_q_empty", 64'(q.size()),   64'd0);
    chk("t5_level",   64'(FIFO_LEVEL), 64'd0);

    // reset on beat 2 truncates the frame; the next frame starts clean
    do_reset();
    FRAME_LEN = 8'd4; TX_DST_RDY_N = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), i == 0, i == 3);
    begin
      int n = 0;
      while (!(!TX_SRC_RDY_N && !TX_SOF_N) && n < 50) begin @(negedge clk); n++; end
      chk("t6_sof_seen", 64'(TX_SOF_N), 64'd0);
    end
    @(posedge clk); #1;
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    q.delete();
    beats = 0;
    chk("t6_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
    chk("t6_level",     64'(FIFO_LEVEL),   64'd0);
    chk("t6_frame_cnt", 64'(FRAME_CNT),    64'd0);
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i), i == 0, i == 3);
    wait_frames(1, 50);
    repeat (2) @(negedge clk);
    chk("t6_beats",   64'(beats),    64'd4);
    chk("t6_q_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurora_tx_framer.md
# aurora_tx_framer

Parametrised LocalLink transmit framer for the Aurora user interface, in the USER_CLK domain. Buffers a valid/ready word stream in an internal single-clock FIFO and emits multi-word frames of programmable length to the Aurora core. A flush timeout sends short frames when traffic stalls. Its improvements over the single-cycle-frame TX engine are:
- multi-word framing,
- proper backpressure on both sides,
- frame accounting.

## Interface
- DATA_W, 32: word width in bits; multiple of 8.
- REM_W, 2: LocalLink REM width, equal to log2(DATA_W/8).
- FIFO_AW, 6: FIFO address width; DEPTH = 2^FIFO_AW words.
- LEN_W, 8: width of FRAME_LEN.
- TO_W, 8: width of FLUSH_TIMEOUT.

- USER_CLK  in  1  only clock.
- RESET  in  1  synchronous reset, active high.
- IN_DATA  in  DATA_W  input word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  FIFO can accept a word.
- FRAME_LEN  in  LEN_W  words per frame. Effective length L = min(max(FRAME_LEN,1), DEPTH).
- FLUSH_TIMEOUT  in  TO_W  idle cycles before a short frame is sent; 0 disables flushing.
- TX_D  out  [0:DATA_W-1]  LocalLink data, big-endian bit order.
- TX_REM  out  [0:REM_W-1]  constant all-ones (full words only).
- TX_SOF_N  out  1  start of frame, active low.
- TX_EOF_N  out  1  end of frame, active low.
- TX_SRC_RDY_N  out  1  source ready, active low.
- TX_DST_RDY_N  in  1  destination ready, active low.
- FIFO_LEVEL  out  FIFO_AW+1  words currently stored.
- FRAME_CNT  out  16  completed frames (EOF beats accepted); wraps at 16 bits.

## Operation
- Push occurs when IN_VALID && IN_READY. IN_READY = (FIFO_LEVEL < DEPTH).
- Beat occurs when !TX_SRC_RDY_N && !TX_DST_RDY_N. Each beat pops one word.
- FIFO is first-word-fall-through. TX_D is always the head word.
- When a push and a pop happen in the same cycle, FIFO_LEVEL is unchanged.
- State machine:
  - IDLE: outputs deasserted.
    - Go to SEND with N = L when FIFO_LEVEL >= L.
    - Otherwise, when the timeout fires and FIFO_LEVEL >= 1, go to SEND with N = FIFO_LEVEL.
    - N and L are latched at the transition. Later changes to FRAME_LEN do not affect the frame in flight.
  - SEND: TX_SRC_RDY_N = 0.
    - TX_SOF_N = 0 on the first beat only.
    - TX_EOF_N = 0 while the beat counter equals N-1.
    - When N = 1, SOF and EOF are asserted together.
    - The beat counter advances only on beats. All outputs are held while TX_DST_RDY_N = 1.
    - The EOF beat increments FRAME_CNT and returns the machine to IDLE.
- Timeout counter:
  - Cleared in SEND, when the FIFO is empty, and when FLUSH_TIMEOUT = 0.
  - Otherwise increments each IDLE cycle, saturating.
  - Fires when it equals FLUSH_TIMEOUT.
- A full-length start has priority over a timeout start in the same cycle.
- Reset clears the FIFO, the beat counter, the timeout counter and FRAME_CNT, and puts the machine in IDLE.
  - A reset mid-frame truncates the frame with no EOF. The Aurora core is reset alongside.

## Timing
- Reset values:
  - TX_SRC_RDY_N = 1, TX_SOF_N = 1, TX_EOF_N = 1.
  - TX_REM = all-ones.
  - IN_READY = 1, FIFO_LEVEL = 0, FRAME_CNT = 0.
  - TX_D = 0.
- Push-to-level latency is 1 cycle: a word pushed in cycle k is counted in FIFO_LEVEL in cycle k+1.
- Start latency: the IDLE decision is made in cycle k+1 on the registered level, so the earliest TX_SRC_RDY_N = 0 is cycle k+2.
- With no backpressure, a frame of N words occupies exactly N consecutive cycles.
- Inter-frame gap is at least 1 IDLE cycle after every EOF beat.
- Sustained throughput at L words per frame is L/(L+1).
- Pops are driven only by beats. Backpressure never loses or duplicates a word.
- FIFO full: IN_READY drops in the cycle FIFO_LEVEL reaches DEPTH and rises the cycle after the first pop.

## Test plan
- Reset, then FRAME_LEN=4, FLUSH_TIMEOUT=0, push words 1..8 back-to-back, TX_DST_RDY_N=0:
  - two 4-beat frames, data 1..4 and 5..8.
  - SOF on beats 1 and 5, EOF on beats 4 and 8.
  - 1-cycle gap between frames; FRAME_CNT=2.
- FRAME_LEN=1, push 0xA5A5A5A5 in cycle k:
  - cycle k+2 shows TX_SRC_RDY_N=0, SOF_N=0, EOF_N=0, TX_D=0xA5A5A5A5.
- FRAME_LEN=8, FLUSH_TIMEOUT=10, push 3 words then stop:
  - after the timeout, one 3-beat frame with SOF on beat 1 and EOF on beat 3; FRAME_CNT=1.
- FRAME_LEN=4, TX_DST_RDY_N toggled pseudo-randomly during a frame:
  - outputs stable while not ready.
  - Exactly 4 beats carry the pushed words in order.
- TX_DST_RDY_N=1 held, IN_VALID=1 continuously:
  - IN_READY=0 at FIFO_LEVEL=64; no word lost.
  - After release, frames drain all 64 words in order.
- RESET asserted on beat 2 of a 4-word frame:
  - the next cycle shows TX_SRC_RDY_N=1, FIFO_LEVEL=0, FRAME_CNT=0.
  - The next frame starts with SOF on fresh data.
